multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller with a built-in memcopy sequencer.
//
// Walks FETCH -> DECODE -> EXEC -> MEM -> WB for the base opcodes and loops
// COPY_RD / COPY_WR for MEMCOPY. Outputs are decoded from the registered state
// and the opcode latched in DECODE; request-completion strobes also look at
// mem_ready, and DECODE looks at the live opcode it is about to latch.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode[6:0]         instruction opcode, consumed in DECODE
//   copy_len[CNT_W-1:0] memcopy word count, consumed in DECODE
//   mem_ready           completes the current memory request
//   pc_write .. op_i    per-state control strobes
//   alu_op[1:0]         00 add, 01 branch compare, 10 R-type funct decode
//   copy_busy           high during the copy loop
//   copy_idx            index of the word being copied
//   instr_done          pulse on the last cycle of each instruction
//   illegal_op          pulse on an unrecognised opcode (TRAP_EN=1 only)
module multicycle_controller #(
  parameter int CNT_W   = 8,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [CNT_W-1:0] copy_len,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             con_jal,
  output logic             con_jalr,
  output logic             con_auipc,
  output logic             con_lui,
  output logic             op_i,
  output logic [1:0]       alu_op,
  output logic             copy_busy,
  output logic [CNT_W-1:0] copy_idx,
  output logic             instr_done,
  output logic             illegal_op
);

  localparam logic [6:0] OP_LW      = 7'b0000011;
  localparam logic [6:0] OP_SW      = 7'b0100011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I       = 7'b0010011;
  localparam logic [6:0] OP_BR      = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_MEMCOPY = 7'b0001000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_COPY_RD,
    S_COPY_WR
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    op_q    <= op_d;
    count_q <= count_d;
    idx_q   <= idx_d;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    idx_d      = idx_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    con_jal    = 1'b0;
    con_jalr   = 1'b0;
    con_auipc  = 1'b0;
    con_lui    = 1'b0;
    op_i       = 1'b0;
    alu_op     = 2'b00;
    copy_busy  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    copy_idx   = idx_q;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_I, OP_BR,
          OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: state_d = S_EXEC;
          OP_MEMCOPY: begin
            count_d = copy_len;
            idx_d   = '0;
            // A zero-length copy retires here without touching memory.
            if (copy_len == '0) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_COPY_RD;
            end
          end
          default: begin
            instr_done = 1'b1;
            illegal_op = TRAP_EN;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        alu_src   = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_I);
        op_i      = (op_q == OP_I);
        con_jal   = (op_q == OP_JAL);
        con_jalr  = (op_q == OP_JALR);
        con_auipc = (op_q == OP_AUIPC);
        con_lui   = (op_q == OP_LUI);
        if (op_q == OP_R)       alu_op = 2'b10;
        else if (op_q == OP_BR) alu_op = 2'b01;
        case (op_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BR: begin
            branch     = 1'b1;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        if (op_q == OP_LW) mem_read  = 1'b1;
        else               mem_write = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        pc_write   = (op_q == OP_JAL) || (op_q == OP_JALR);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_COPY_RD: begin
        copy_busy = 1'b1;
        mem_read  = 1'b1;
        if (mem_ready) state_d = S_COPY_WR;
      end

      S_COPY_WR: begin
        copy_busy = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          if (count_q == CNT_W'(1)) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            count_d = count_q - CNT_W'(1);
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_COPY_RD;
          end
        end
      end

      default: state_d = S_FETCH;
    endcase

    // Reset masks every strobe combinationally so an aborted request cannot
    // leak a final pulse in the cycle rst is sampled.
    if (rst) begin
      state_d    = S_FETCH;
      op_d       = '0;
      count_d    = '0;
      idx_d      = '0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      con_jal    = 1'b0;
      con_jalr   = 1'b0;
      con_auipc  = 1'b0;
      con_lui    = 1'b0;
      op_i       = 1'b0;
      alu_op     = 2'b00;
      copy_busy  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      copy_idx   = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// by a transaction-level model into its list of expected cycles (request
// phases with chosen wait counts, single-cycle phases), then replayed against
// two instances (TRAP_EN=1 and TRAP_EN=0) sharing the same stimulus.
module tb_multicycle_controller;

  localparam int CW = 8;

  localparam int B_PCW = 17, B_IRW = 16, B_MRD = 15, B_MWR = 14, B_RGW = 13;
  localparam int B_ASRC = 12, B_M2R = 11, B_BR = 10, B_JAL = 9, B_JALR = 8;
  localparam int B_AUIPC = 7, B_LUI = 6, B_OPI = 5, B_AOP = 3;
  localparam int B_BUSY = 2, B_DONE = 1, B_ILL = 0;

  localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_I = 4, K_BR = 5;
  localparam int K_JAL = 6, K_JALR = 7, K_AUIPC = 8, K_LUI = 9, K_MC = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [CW-1:0] copy_len;
  logic          mem_ready;

  logic          pcw_a, irw_a, mrd_a, mwr_a, rgw_a, asrc_a, m2r_a, br_a;
  logic          jal_a, jalr_a, auipc_a, lui_a, opi_a, busy_a, done_a, ill_a;
  logic [1:0]    aop_a;
  logic [CW-1:0] idx_a;
  logic          pcw_b, irw_b, mrd_b, mwr_b, rgw_b, asrc_b, m2r_b, br_b;
  logic          jal_b, jalr_b, auipc_b, lui_b, opi_b, busy_b, done_b, ill_b;
  logic [1:0]    aop_b;
  logic [CW-1:0] idx_b;

  multicycle_controller #(.CNT_W(CW), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .copy_len(copy_len), .mem_ready(mem_ready),
    .pc_write(pcw_a), .ir_write(irw_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .reg_write(rgw_a), .alu_src(asrc_a), .mem_to_reg(m2r_a), .branch(br_a),
    .con_jal(jal_a), .con_jalr(jalr_a), .con_auipc(auipc_a), .con_lui(lui_a),
    .op_i(opi_a), .alu_op(aop_a), .copy_busy(busy_a), .copy_idx(idx_a),
    .instr_done(done_a), .illegal_op(ill_a)
  );

  multicycle_controller #(.CNT_W(CW), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode), .copy_len(copy_len), .mem_ready(mem_ready),
    .pc_write(pcw_b), .ir_write(irw_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .reg_write(rgw_b), .alu_src(asrc_b), .mem_to_reg(m2r_b), .branch(br_b),
    .con_jal(jal_b), .con_jalr(jalr_b), .con_auipc(auipc_b), .con_lui(lui_b),
    .op_i(opi_b), .alu_op(aop_b), .copy_busy(busy_b), .copy_idx(idx_b),
    .instr_done(done_b), .illegal_op(ill_b)
  );

  logic [17:0] obs_a, obs_b;
  assign obs_a = {pcw_a, irw_a, mrd_a, mwr_a, rgw_a, asrc_a, m2r_a, br_a, jal_a, jalr_a,
                  auipc_a, lui_a, opi_a, aop_a, busy_a, done_a, ill_a};
  assign obs_b = {pcw_b, irw_b, mrd_b, mwr_b, rgw_b, asrc_b, m2r_b, br_b, jal_b, jalr_b,
                  auipc_b, lui_b, opi_b, aop_b, busy_b, done_b, ill_b};

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]   vec;
    logic [CW-1:0] idx;
    logic          ready;
    logic          dec;
  } cyc_t;

  cyc_t        q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_idx = 0;
  logic [6:0]  cur_op;
  int unsigned cur_len;

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0010111: return K_AUIPC;
      7'b0110111: return K_LUI;
      7'b0001000: return K_MC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int unsigned nwait(input int unsigned wmax, input int fixed);
    if (fixed >= 0) return fixed;
    return $urandom_range(wmax, 0);
  endfunction

  task automatic push(input logic [17:0] v, input int unsigned ix, input logic rdy, input logic dec);
    cyc_t c;
    c.vec = v; c.idx = CW'(ix); c.ready = rdy; c.dec = dec;
    q.push_back(c);
  endtask

  // A memory request: n stall cycles, then the completing cycle with extra strobes.
  task automatic push_req(input logic [17:0] v, input logic [17:0] on_done,
                          input int unsigned ix, input int unsigned n);
    repeat (n) push(v, ix, 1'b0, 1'b0);
    push(v | on_done, ix, 1'b1, 1'b0);
  endtask

  task automatic build_instr(input logic [6:0] op, input int unsigned len,
                             input int unsigned wmax, input int fixed);
    logic [17:0] v, d;
    int k;
    k = kind_of(op);
    q.delete();
    cur_op = op;
    cur_len = len;
    v = '0; v[B_MRD] = 1'b1;
    d = '0; d[B_IRW] = 1'b1; d[B_PCW] = 1'b1;
    push_req(v, d, exp_idx, nwait(wmax, fixed));
    v = '0;
    if (k == K_ILL) begin
      v[B_DONE] = 1'b1; v[B_ILL] = 1'b1;
      push(v, exp_idx, 1'($urandom % 2), 1'b1);
      return;
    end
    if (k == K_MC) begin
      v[B_DONE] = (len == 0);
      push(v, exp_idx, 1'($urandom % 2), 1'b1);
      exp_idx = 0;
      for (int unsigned i = 0; i < len; i++) begin
        v = '0; v[B_BUSY] = 1'b1; v[B_MRD] = 1'b1;
        push_req(v, '0, i, nwait(wmax, fixed));
        v = '0; v[B_BUSY] = 1'b1; v[B_MWR] = 1'b1;
        d = '0; d[B_DONE] = (i == len - 1);
        push_req(v, d, i, nwait(wmax, fixed));
        exp_idx = i;
      end
      return;
    end
    push(v, exp_idx, 1'($urandom % 2), 1'b1);
    v = '0;
    v[B_ASRC]  = (k == K_LW) || (k == K_SW) || (k == K_I);
    v[B_OPI]   = (k == K_I);
    v[B_JAL]   = (k == K_JAL);
    v[B_JALR]  = (k == K_JALR);
    v[B_AUIPC] = (k == K_AUIPC);
    v[B_LUI]   = (k == K_LUI);
    v[B_AOP+1] = (k == K_R);
    v[B_AOP]   = (k == K_BR);
    if (k == K_BR) begin
      v[B_BR] = 1'b1; v[B_PCW] = 1'b1; v[B_DONE] = 1'b1;
    end
    push(v, exp_idx, 1'($urandom % 2), 1'b0);
    if (k == K_BR) return;
    if (k == K_LW || k == K_SW) begin
      v = '0; d = '0;
      if (k == K_LW) v[B_MRD] = 1'b1;
      else begin v[B_MWR] = 1'b1; d[B_DONE] = 1'b1; end
      push_req(v, d, exp_idx, nwait(wmax, fixed));
      if (k == K_SW) return;
    end
    v = '0;
    v[B_RGW] = 1'b1; v[B_M2R] = (k == K_LW);
    v[B_PCW] = (k == K_JAL) || (k == K_JALR); v[B_DONE] = 1'b1;
    push(v, exp_idx, 1'($urandom % 2), 1'b0);
  endtask

  // Replays q; abort_at >= 0 replaces that cycle with two reset cycles.
  task automatic apply(input string tag, input int abort_at);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        for (int r = 0; r < 2; r++) begin
          if (r > 0) @(negedge clk);
          rst = 1'b1; mem_ready = 1'($urandom % 2); opcode = 7'($urandom); copy_len = CW'($urandom);
          #1;
          vectors += 3;
          if (obs_a !== 18'd0) begin miscompares++; $display("FAIL %s rst_ctrl cyc %0d: got %b want %b", tag, k, obs_a, 18'd0); end
          if (obs_b !== 18'd0) begin miscompares++; $display("FAIL %s rst_ctrl_nt cyc %0d: got %b want %b", tag, k, obs_b, 18'd0); end
          if (idx_a !== '0 || idx_b !== '0) begin miscompares++; $display("FAIL %s rst_idx cyc %0d: got %0d/%0d want 0", tag, k, idx_a, idx_b); end
        end
        exp_idx = 0;
        return;
      end
      rst = 1'b0;
      mem_ready = q[k].ready;
      opcode = q[k].dec ? cur_op : 7'($urandom);
      copy_len = q[k].dec ? CW'(cur_len) : CW'($urandom);
      #1;
      vectors += 3;
      if (obs_a !== q[k].vec) begin
        miscompares++; $display("FAIL %s ctrl cyc %0d: got %b want %b", tag, k, obs_a, q[k].vec);
      end
      if (obs_b !== (q[k].vec & ~18'd1)) begin
        miscompares++; $display("FAIL %s ctrl_notrap cyc %0d: got %b want %b", tag, k, obs_b, q[k].vec & ~18'd1);
      end
      if (idx_a !== q[k].idx || idx_b !== q[k].idx) begin
        miscompares++; $display("FAIL %s copy_idx cyc %0d: got %0d/%0d want %0d", tag, k, idx_a, idx_b, q[k].idx);
      end
    end
  endtask

  task automatic test_reset();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'($urandom % 2); opcode = 7'($urandom);
      #1;
      vectors += 2;
      if (obs_a !== 18'd0 || obs_b !== 18'd0) begin
        miscompares++; $display("FAIL reset ctrl: got %b/%b want 0", obs_a, obs_b);
      end
      if (idx_a !== '0 || idx_b !== '0) begin
        miscompares++; $display("FAIL reset copy_idx: got %0d/%0d want 0", idx_a, idx_b);
      end
    end
    exp_idx = 0;
  endtask

  task automatic test_rtype();
    repeat (3) begin build_instr(7'b0110011, 0, 0, 0); apply("rtype", -1); end
  endtask

  task automatic test_lw_wait();
    build_instr(7'b0000011, 0, 0, 3); apply("lw_wait", -1);
    build_instr(7'b0100011, 0, 0, 2); apply("sw_wait", -1);
  endtask

  task automatic test_memcopy3();
    build_instr(7'b0001000, 3, 0, 0);
    if (q.size() != 8) begin miscompares++; $display("FAIL memcopy3 length: got %0d want 8", q.size()); end
    vectors++;
    apply("memcopy3", -1);
  endtask

  task automatic test_memcopy0();
    build_instr(7'b0001000, 0, 0, 1); apply("memcopy0", -1);
  endtask

  task automatic test_illegal();
    build_instr(7'b1111111, 0, 0, 0); apply("illegal", -1);
  endtask

  task automatic test_reset_midcopy();
    // Cycle 9 is the stalled first cycle of the second COPY_WR with one wait per request.
    build_instr(7'b0001000, 3, 0, 1); apply("rst_midcopy", 9);
    build_instr(7'b0000011, 0, 0, 0); apply("after_rst", -1);
  endtask

  task automatic test_max_copy();
    build_instr(7'b0001000, 255, 0, 0); apply("max_copy", -1);
  endtask

  task automatic test_random();
    logic [6:0] legal [10];
    logic [6:0] op;
    int ab;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b0001000};
    for (int n = 0; n < 150; n++) begin
      if ($urandom % 8 == 0) begin
        op = 7'($urandom);
        while (kind_of(op) != K_ILL) op = 7'($urandom);
      end else begin
        op = legal[$urandom_range(9, 0)];
      end
      build_instr(op, $urandom_range(5, 0), 3, -1);
      ab = ($urandom % 8 == 0) ? $urandom_range(q.size() - 1, 0) : -1;
      apply("random", ab);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; copy_len = '0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_memcopy3();
    test_memcopy0();
    test_illegal();
    test_reset_midcopy();
    test_max_copy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
